// File: rtl/lcd_16207_responder.sv
// Responder model of a 16x2 HD44780-class character LCD with host bus and debug viewer port.
// Optional protocol checker: define LCD_16207_RESPONDER_CHECK_EN to build the sticky protocol_err logic.
module lcd_16207_responder #(
    parameter int BUSY_CYCLES = 40,
    parameter int HOME_CYCLES = 1600,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [4:0] disp_addr,
    output logic [7:0] disp_char,
    output logic       busy,
    output logic       protocol_err
);

    localparam int MAX_CYC = (HOME_CYCLES > BUSY_CYCLES) ? HOME_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam int SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [SYNC_N-1:0] e_sync, rs_sync, rw_sync;
    logic              e_s, rs_s, rw_s, e_q;
    logic              e_rise, e_fall;
    logic              rs_lat, rw_lat;
    logic [6:0]        ac;
    logic              inc_mode;
    logic              cgram_mode;
    logic [2:0]        disp_ctl;
    logic [2:0]        func_set;
    logic [CNT_W-1:0]  cnt;
    logic [79:0]       valid;
    logic [7:0]        ddram [80];
    logic [6:0]        ac_idx, view_idx;
    logic [7:0]        ac_rd;
    logic              wr_fire, ram_we;
    logic              status_unused;

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h40)      r = 7'h27;
            else if (a == 7'h00) r = 7'h67;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    // Columns past 39 fall back to the start of the line selected by bit 6.
    function automatic logic [6:0] ac_set(input logic [6:0] d);
        return (d[5:0] > 6'd39) ? {d[6], 6'd0} : d;
    endfunction

    function automatic logic [6:0] ram_index(input logic line, input logic [5:0] col);
        return line ? (7'd40 + {1'b0, col}) : {1'b0, col};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_sync  <= '0;
            rs_sync <= '0;
            rw_sync <= '0;
            e_q     <= 1'b0;
        end else begin
            e_sync  <= {e_sync[SYNC_N-2:0], LCD_E};
            rs_sync <= {rs_sync[SYNC_N-2:0], LCD_RS};
            rw_sync <= {rw_sync[SYNC_N-2:0], LCD_RW};
            e_q     <= e_s;
        end
    end

    assign e_s      = e_sync[SYNC_N-1];
    assign rs_s     = rs_sync[SYNC_N-1];
    assign rw_s     = rw_sync[SYNC_N-1];
    assign e_rise   = e_s & ~e_q;
    assign e_fall   = ~e_s & e_q;
    assign wr_fire  = e_fall & ~rw_lat & ~busy;
    assign ram_we   = wr_fire & rs_lat & ~cgram_mode;
    assign ac_idx   = ram_index(ac[6], ac[5:0]);
    assign view_idx = ram_index(disp_addr[4], {2'b00, disp_addr[3:0]});
    assign ac_rd    = valid[ac_idx] ? ddram[ac_idx] : 8'h20;

    // Display/function bits are held for completeness only; nothing downstream consumes them.
    assign status_unused = ^{disp_ctl, func_set};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs_lat       <= 1'b0;
            rw_lat       <= 1'b0;
            ac           <= 7'h00;
            inc_mode     <= 1'b1;
            cgram_mode   <= 1'b0;
            disp_ctl     <= 3'b000;
            func_set     <= 3'b000;
            busy         <= 1'b0;
            cnt          <= '0;
            valid        <= '0;
            lcd_data_out <= 8'h00;
            lcd_data_oe  <= 1'b0;
        end else begin
            if (e_rise) begin
                rs_lat <= rs_s;
                rw_lat <= rw_s;
                if (rw_s) begin
                    lcd_data_oe  <= 1'b1;
                    lcd_data_out <= rs_s ? ac_rd : {busy, ac};
                end
            end

            if (e_fall) begin
                lcd_data_oe <= 1'b0;
                if (rw_lat && rs_lat)
                    ac <= ac_step(ac, inc_mode);
            end

            if (wr_fire) begin
                busy <= 1'b1;
                cnt  <= CNT_W'(BUSY_CYCLES - 1);
                if (rs_lat) begin
                    if (!cgram_mode)
                        valid[ac_idx] <= 1'b1;
                    ac <= ac_step(ac, inc_mode);
                end else begin
                    casez (lcd_data_in)
                        8'b1???????: begin
                            ac         <= ac_set(lcd_data_in[6:0]);
                            cgram_mode <= 1'b0;
                        end
                        8'b01??????: cgram_mode <= 1'b1;
                        8'b001?????: func_set <= lcd_data_in[4:2];
                        8'b0001????: begin
                            if (!lcd_data_in[3])
                                ac <= ac_step(ac, lcd_data_in[2]);
                        end
                        8'b00001???: disp_ctl <= lcd_data_in[2:0];
                        8'b000001??: inc_mode <= lcd_data_in[1];
                        8'b0000001?: begin
                            ac  <= 7'h00;
                            cnt <= CNT_W'(HOME_CYCLES - 1);
                        end
                        8'b00000001: begin
                            valid    <= '0;
                            ac       <= 7'h00;
                            inc_mode <= 1'b1;
                            cnt      <= CNT_W'(HOME_CYCLES - 1);
                        end
                        default: ;
                    endcase
                end
            end else if (busy) begin
                if (cnt == '0)
                    busy <= 1'b0;
                else
                    cnt <= cnt - 1'b1;
            end
        end
    end

    // Storage has no reset; the valid bits make never-written or cleared cells read as space.
    always_ff @(posedge clk) begin
        if (ram_we)
            ddram[ac_idx] <= lcd_data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            disp_char <= 8'h20;
        else
            disp_char <= valid[view_idx] ? ddram[view_idx] : 8'h20;
    end

`ifdef LCD_16207_RESPONDER_CHECK_EN
    logic [1:0] hi_cnt;
    logic       err;

    // hi_cnt holds the number of cycles synchronized E has been high, saturating at 3.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_cnt <= 2'd0;
            err    <= 1'b0;
        end else begin
            if (e_rise)
                hi_cnt <= 2'd1;
            else if (e_s && hi_cnt != 2'd3)
                hi_cnt <= hi_cnt + 2'd1;
            if ((e_fall && !rw_lat && busy) ||
                (e_s && e_q && (rs_s != rs_lat || rw_s != rw_lat)) ||
                (e_fall && hi_cnt < 2'd2))
                err <= 1'b1;
        end
    end

    assign protocol_err = err;
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_16207_responder.sv
// Directed self-checking bench for lcd_16207_responder: host command/data traffic, status reads and viewer port.
module tb_lcd_16207_responder;

    logic       clk;
    logic       reset_n;
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic [4:0] disp_addr;
    logic [7:0] disp_char;
    logic       busy;
    logic       protocol_err;

    int         vectors;
    int         miscompares;
    int         busy_len;
    int         oe_n;
    logic [7:0] rd;
    logic [7:0] ch;
    logic       drop_err_exp;

    lcd_16207_responder #(
        .BUSY_CYCLES(40),
        .HOME_CYCLES(1600),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .LCD_E        (lcd_e),
        .LCD_RS       (lcd_rs),
        .LCD_RW       (lcd_rw),
        .lcd_data_in  (lcd_data_in),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .disp_addr    (disp_addr),
        .disp_char    (disp_char),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Write strobe with E high for four cycles; returns two cycles after E drops.
    task automatic apply_stimulus(input logic rs, input logic [7:0] d);
        @(negedge clk);
        lcd_rs      = rs;
        lcd_rw      = 1'b0;
        lcd_data_in = d;
        lcd_e       = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Strobe, then count the cycles BF stays high until it drops.
    task automatic host_write(input logic rs, input logic [7:0] d);
        apply_stimulus(rs, d);
        busy_len = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy) busy_len++;
            else if (busy_len > 0 || i > 4) break;
        end
    endtask

    task automatic host_read(input logic rs, output logic [7:0] val, output int oe_cnt);
        @(negedge clk);
        val    = 8'hxx;
        lcd_rs = rs;
        lcd_rw = 1'b1;
        lcd_e  = 1'b1;
        oe_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (lcd_data_oe) oe_cnt++;
            if (i == 6) begin
                val   = lcd_data_out;
                lcd_e = 1'b0;
            end
        end
        lcd_rw = 1'b0;
        lcd_rs = 1'b0;
    endtask

    task automatic view(input logic [4:0] a, output logic [7:0] c);
        @(negedge clk);
        disp_addr = a;
        repeat (2) @(negedge clk);
        c = disp_char;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        check_output("ready_timeout", busy, 1'b0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        lcd_e        = 1'b0;
        lcd_rs       = 1'b0;
        lcd_rw       = 1'b0;
        lcd_data_in  = 8'h00;
        disp_addr    = 5'h00;
`ifdef LCD_16207_RESPONDER_CHECK_EN
        drop_err_exp = 1'b1;
`else
        drop_err_exp = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_oe", lcd_data_oe, 1'b0);
        check_output("rst_dout", lcd_data_out, 8'h00);
        check_output("rst_disp", disp_char, 8'h20);
        check_output("rst_perr", protocol_err, 1'b0);
        reset_n = 1'b1;

        host_read(1'b0, rd, oe_n);
        check_output("status_after_reset", rd, 8'h00);
        check_output("status_oe_window", oe_n, 6);
        view(5'h00, ch);
        check_output("view_00_reset", ch, 8'h20);
        view(5'h1F, ch);
        check_output("view_1f_reset", ch, 8'h20);

        host_write(1'b0, 8'h80);
        check_output("bf_len_setaddr", busy_len, 40);
        host_write(1'b1, 8'h41);
        check_output("bf_len_data41", busy_len, 40);
        host_write(1'b1, 8'h42);
        check_output("bf_len_data42", busy_len, 40);
        view(5'h00, ch);
        check_output("view_l0c0", ch, 8'h41);
        view(5'h01, ch);
        check_output("view_l0c1", ch, 8'h42);
        host_read(1'b0, rd, oe_n);
        check_output("status_ac02", rd, 8'h02);

        host_write(1'b0, 8'hA7);
        host_write(1'b1, 8'h58);
        host_read(1'b0, rd, oe_n);
        check_output("status_wrap_inc", rd, 8'h40);
        host_write(1'b0, 8'h04);
        host_write(1'b1, 8'h59);
        host_read(1'b0, rd, oe_n);
        check_output("status_wrap_dec", rd, 8'h27);
        view(5'h10, ch);
        check_output("view_l1c0", ch, 8'h59);
        check_output("perr_clean", protocol_err, 1'b0);

        host_write(1'b0, 8'h01);
        check_output("bf_len_clear", busy_len, 1600);
        apply_stimulus(1'b0, 8'h01);
        apply_stimulus(1'b1, 8'h5A);
        wait_ready();
        check_output("perr_busy_write", protocol_err, drop_err_exp);
        for (int i = 0; i < 32; i++) begin
            view(5'(i), ch);
            check_output($sformatf("view_cleared_%0d", i), ch, 8'h20);
        end
        host_read(1'b0, rd, oe_n);
        check_output("status_after_clear", rd, 8'h00);

        host_write(1'b0, 8'hC0);
        host_write(1'b1, 8'h31);
        host_write(1'b1, 8'h32);
        host_write(1'b0, 8'hC0);
        host_read(1'b1, rd, oe_n);
        check_output("data_read", rd, 8'h31);
        check_output("data_read_oe_window", oe_n, 6);
        check_output("oe_idle", lcd_data_oe, 1'b0);
        host_read(1'b0, rd, oe_n);
        check_output("status_after_dread", rd, 8'h41);
        view(5'h11, ch);
        check_output("view_l1c1", ch, 8'h32);

        host_write(1'b0, 8'hB5);
        host_read(1'b0, rd, oe_n);
        check_output("setaddr_out_of_range", rd, 8'h00);
        host_write(1'b0, 8'h04);
        host_write(1'b1, 8'h33);
        host_read(1'b0, rd, oe_n);
        check_output("dec_wrap_00", rd, 8'h67);
        host_write(1'b0, 8'h06);
        host_write(1'b1, 8'h34);
        host_write(1'b0, 8'h14);
        host_read(1'b0, rd, oe_n);
        check_output("inc_wrap_then_shift", rd, 8'h01);
        view(5'h00, ch);
        check_output("view_l0c0_33", ch, 8'h33);

        apply_stimulus(1'b0, 8'h01);
        host_read(1'b0, rd, oe_n);
        check_output("status_busy", rd, 8'h80);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_output("reset_abort_busy", busy, 1'b0);
        check_output("reset_perr", protocol_err, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        host_read(1'b0, rd, oe_n);
        check_output("status_after_abort", rd, 8'h00);
        host_write(1'b1, 8'h44);
        check_output("bf_len_after_abort", busy_len, 40);
        check_output("perr_after_abort", protocol_err, 1'b0);
        view(5'h00, ch);
        check_output("view_after_abort", ch, 8'h44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_16207_responder.md
Name: lcd_16207_responder

Overview:
- Synthesizable model of the 16x2 HD44780-class character LCD. It sits on the far end of the LCD_E/LCD_RS/LCD_RW/LCD_data bus that the NIOS LCD port drives.
- It decodes commands and data, keeps the address counter, the DDRAM and the busy flag, and answers status and data reads.
- Used in system simulation and as an on-chip LCD emulator. A second read port feeds a debug/VGA viewer.

Parameters:
- BUSY_CYCLES, 40, clk cycles BF stays set after any write except clear and home.
- HOME_CYCLES, 1600, clk cycles BF stays set after clear display or return home.
- SYNC_STAGES, 2, synchronizer depth on LCD_E, LCD_RS and LCD_RW (minimum 2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- LCD_E  in  1  enable strobe from the host.
- LCD_RS  in  1  register select: 0 = instruction/status, 1 = data.
- LCD_RW  in  1  1 = read, 0 = write.
- lcd_data_in  in  8  bus value sampled on writes.
- lcd_data_out  out  8  bus value driven on reads.
- lcd_data_oe  out  1  enables the top-level tristate.
- disp_addr  in  5  viewer index: bit4 = line, bits3:0 = column 0..15.
- disp_char  out  8  DDRAM byte at the visible position, 1-cycle latency.
- busy  out  1  mirror of BF.
- protocol_err  out  1  sticky error flag (optional feature).

Behaviour:
- Reset values:
  - AC = 0x00, I/D = 1, D/C/B = 0, BF = 0.
  - lcd_data_out = 0x00, lcd_data_oe = 0, disp_char = 0x20, protocol_err = 0.
  - DDRAM (80 B) reads as 0x20 after reset. Either clear the array in a background sweep, or use a valid bit per location.
- Reset asserted mid-operation aborts any busy countdown immediately.
- Strobe handling: E, RS and RW pass through the synchronizers. RS and RW are qualified at the synchronized E rising edge and held in registers until the matching falling edge.
- Write: fires on the synchronized E falling edge with RW = 0. lcd_data_in is sampled in that cycle.
- Read: with RW = 1, lcd_data_oe is asserted from the E rising edge (+SYNC_STAGES) until the falling edge (+SYNC_STAGES).
  - RS = 0 read returns {BF, AC[6:0]}.
  - RS = 1 read returns the DDRAM byte at AC. AC then advances per I/D at the falling edge.
- Instruction decode, first set bit wins, MSB down:
  - 1xxxxxxx: AC = d[6:0]. Leave CGRAM mode.
  - 01xxxxxx: enter CGRAM mode. Later data writes are accepted but discarded; AC still advances.
  - 001xxxxx: latch DL/N/F into a status register. No functional effect; always 8-bit, 2-line.
  - 0001xxxx: if S/C = 0, move AC by R/L (+1 or -1 with wrap). If S/C = 1, no-op.
  - 00001xxx: latch D/C/B.
  - 000001xx: I/D = d1. S ignored.
  - 0000001x: AC = 0. BF for HOME_CYCLES.
  - 00000001: DDRAM all 0x20, AC = 0, I/D = 1. BF for HOME_CYCLES. Fill completes within that window.
  - 00000000: no-op.
- Data write: DDRAM[AC] = d, then AC advances per I/D.
- AC space is 0x00-0x27 (line 0) and 0x40-0x67 (line 1). Stepping:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x40 -> 0x27, 0x00 -> 0x67.
  - Set-address values outside both ranges wrap to the start of the line named by bit 6.
  - DDRAM index = line*40 + col.
- BF: set in the cycle a write completes. Counter loads BUSY_CYCLES-1 or HOME_CYCLES-1; BF clears when the counter reaches 0.
- Writes while BF = 1 are ignored; AC and DDRAM unchanged. Reads are always honoured.
- disp_char = DDRAM[line*40 + col] with 1-cycle latency. Independent of host traffic.
- Same-cycle viewer read and host write to one location: viewer returns the old value.
- If D = 0 the viewer still returns stored characters; blanking is the viewer's job.

Optional Feature:
- Macro: LCD_16207_RESPONDER_CHECK_EN.
- Defined: protocol_err is set, and held until reset, by any of:
  - a write while BF = 1;
  - RS or RW changing while the synchronized E is high;
  - an E high pulse shorter than 2 clk after synchronization.
- Undefined: protocol_err is tied 0 and the checking logic is not built. Busy-write drop behaviour is unchanged.

Test Plan:
- Reset, then read status (RS = 0, RW = 1) -> 0x00. Viewer at addr 0x00 and 0x1F -> 0x20.
- Write instr 0x80, then data 0x41 and 0x42, each after BF clears -> viewer line0 col0 = 0x41, col1 = 0x42. Status read -> 0x02. BF high for exactly BUSY_CYCLES after each write.
- Write instr 0xA7 (AC = 0x27), then data 0x58 -> status read -> 0x40. Instr 0x04 (decrement), then data 0x59 at AC = 0x40 -> AC = 0x27.
- Write 0x01 -> BF high for HOME_CYCLES. Data write 0x5A during BF is dropped (protocol_err = 1 with CHECK_EN). Afterwards all 32 viewer positions = 0x20 and status = 0x00.
- Instr 0xC0, data 0x31, 0x32; instr 0xC0; data read -> 0x31, and AC reads back as 0x41. lcd_data_oe is high only inside the E window.
- Assert reset_n while BF = 1 after a clear -> BF = 0 and AC = 0 immediately. The next write is accepted with no error.
